lane_gate_ctrl: RTL
===================

// Module: lane_gate_ctrl
// PURPOSE
//  Sequences the single-lane barrier of the parking lot; the lane is shared by entry and exit requesters.
//  Entry and exit push-button requests are arbitrated round-robin, the barrier is opened for the winner,
//  and the occupancy count from the car counter is watched to detect passage completion.
//  Full and empty lot states gate eligibility. A timeout closes the barrier if no car passes.
// PARAMETERS
//  COUNT_W        3   width of occupancy count
//  CAPACITY       7   max cars; entry refused when count >= CAPACITY
//  TIMEOUT_CYCLES 16  max cycles barrier stays open awaiting passage (>=2)
//  GUARD_CYCLES   2   cycles barrier held closed after a phase before next grant (>=1)
//  TMR_W          5   timer width, must hold max(TIMEOUT_CYCLES,GUARD_CYCLES)
// PORTS
//  clk          in   1        system clock, rising edge
//  reset        in   1        asynchronous, active-high reset
//  req_in       in   1        entry request, level, held by driver until grant_in seen
//  req_out      in   1        exit request, level, held until grant_out seen
//  count        in   COUNT_W  occupancy from car counter (+1 per entry, -1 per exit)
//  gate_open    out  1        barrier open command
//  grant_in     out  1        lane granted to entry (one-hot with grant_out)
//  grant_out    out  1        lane granted to exit
//  lot_full     out  1        registered: count >= CAPACITY
//  busy         out  1        state != IDLE
//  timeout_evt  out  1        one-cycle pulse: phase ended by timeout
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, timer=0, ref=0, last_grant=OUT (so first tie goes to entry).
//  All outputs registered; 1-cycle latency from input sample to output.
//  Eligibility: in_ok = req_in & (count < CAPACITY); out_ok = req_out & (count != 0).
//  IDLE: in_ok only -> OPEN_IN; out_ok only -> OPEN_OUT; both -> direction != last_grant;
//        neither -> stay. On transition: ref<=count, timer<=0, last_grant updated,
//        gate_open=1 and matching grant=1 from next cycle.
//  OPEN_IN: count==ref+1 -> CLOSE (completion). Other count changes: ref<=count, stay.
//        timer==TIMEOUT_CYCLES-1 without completion -> CLOSE, timeout_evt=1 for one cycle.
//        Completion and timeout in same cycle: completion wins, no timeout_evt.
//  OPEN_OUT: same, completion is count==ref-1.
//  CLOSE: gate_open=0, grants=0, timer counts GUARD_CYCLES cycles then IDLE.
//        Requests in CLOSE are not sampled; re-evaluated in IDLE.
//  Count compare in COUNT_W+1 bits: no wrap at ref=max or ref=0.
//  Request dropped while OPEN: no effect; phase ends only by completion or timeout.
//  reset asserted mid-phase: barrier closes immediately (async), return to IDLE.
//  lot_full updates every cycle from count, independent of state.
// STRUCTURE
//  park_defs.vh: state encodings (IDLE, OPEN_IN, OPEN_OUT, CLOSE), default CAPACITY/COUNT_W,
//  shared with the car counter and top level.
//  Sub-module rr_arb2: 2-request round-robin arbiter (req[1:0], last, gnt[1:0]), combinational.
//  FSM + timer + ref register in lane_gate_ctrl.
// TESTING
//  1 req_in=1, count=0 -> grant_in,gate_open=1 next cycle; count->1 -> CLOSE, idle after 2 cycles.
//  2 req_in=req_out=1, count=3 after reset -> grant_in first; then grant_out; then alternate.
//  3 count=7, req_in=1 -> no grant, lot_full=1; count=0, req_out=1 -> no grant, busy=0.
//  4 grant_in, count held -> gate closes after 16 cycles, timeout_evt single pulse, no further grant during guard.
//  5 count reaches ref+1 in cycle 15 of open -> completion, timeout_evt stays 0.
//  6 reset pulse during OPEN_OUT -> gate_open=0 same timestep, state IDLE, all outputs 0.

Source files
------------

// File: rtl/lane_gate_ctrl_pkg.sv
// Shared definitions for the parking-lane barrier controller: phase encodings,
// lane direction codes and default sizing.
package lane_gate_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      OPEN_IN  = 2'd1,
      OPEN_OUT = 2'd2,
      CLOSE    = 2'd3
   } gate_state_e;

   // Direction codes double as arbiter request/grant indices.
   localparam logic DIR_IN  = 1'b0;
   localparam logic DIR_OUT = 1'b1;

   localparam int DEF_COUNT_W        = 3;
   localparam int DEF_CAPACITY       = 7;
   localparam int DEF_TIMEOUT_CYCLES = 16;
   localparam int DEF_GUARD_CYCLES   = 2;
   localparam int DEF_TMR_W          = 5;

endpackage

// File: rtl/lane_gate_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; on a tie the requester that did not win last time is granted.
module rr_arb2
   import lane_gate_ctrl_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   assign gnt[DIR_IN]  = req[DIR_IN]  & (~req[DIR_OUT] | (last == DIR_OUT));
   assign gnt[DIR_OUT] = req[DIR_OUT] & (~req[DIR_IN]  | (last == DIR_IN));

endmodule

// File: rtl/lane_gate_ctrl.sv
// Single-lane barrier sequencer: arbitrates entry/exit, opens the gate for the winner,
// watches the occupancy count for passage, and enforces timeout and a closed guard period.
module lane_gate_ctrl
   import lane_gate_ctrl_pkg::*;
#(
   parameter int COUNT_W        = DEF_COUNT_W,
   parameter int CAPACITY       = DEF_CAPACITY,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int GUARD_CYCLES   = DEF_GUARD_CYCLES,
   parameter int TMR_W          = DEF_TMR_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req_in,
   input  logic               req_out,
   input  logic [COUNT_W-1:0] count,
   output logic               gate_open,
   output logic               grant_in,
   output logic               grant_out,
   output logic               lot_full,
   output logic               busy,
   output logic               timeout_evt
);

   localparam logic [COUNT_W:0] CAP_X    = (COUNT_W+1)'(CAPACITY);
   localparam logic [COUNT_W:0] ONE_X    = (COUNT_W+1)'(1);
   localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TMR_W-1:0] GRD_LAST = TMR_W'(GUARD_CYCLES - 1);

   gate_state_e        state;
   logic [TMR_W-1:0]   timer;
   logic [COUNT_W-1:0] ref_cnt;
   logic               last_grant;
   logic [1:0]         req_ok;
   logic [1:0]         gnt;
   logic [COUNT_W:0]   cnt_x;
   logic [COUNT_W:0]   ref_x;
   logic               done;

   // One extra bit so ref+1 at full scale and ref-1 at zero cannot alias a real count.
   assign cnt_x = {1'b0, count};
   assign ref_x = {1'b0, ref_cnt};
   assign done  = (state == OPEN_IN)  ? (cnt_x == ref_x + ONE_X) :
                  (state == OPEN_OUT) ? (cnt_x == ref_x - ONE_X) : 1'b0;

   assign req_ok[DIR_IN]  = req_in  & (cnt_x < CAP_X);
   assign req_ok[DIR_OUT] = req_out & (count != '0);

   rr_arb2 u_arb (
      .req  (req_ok),
      .last (last_grant),
      .gnt  (gnt)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         timer       <= '0;
         ref_cnt     <= '0;
         last_grant  <= DIR_OUT;
         gate_open   <= 1'b0;
         grant_in    <= 1'b0;
         grant_out   <= 1'b0;
         lot_full    <= 1'b0;
         busy        <= 1'b0;
         timeout_evt <= 1'b0;
      end else begin
         lot_full    <= (cnt_x >= CAP_X);
         timeout_evt <= 1'b0;
         unique case (state)
            IDLE: begin
               if (gnt[DIR_IN] || gnt[DIR_OUT]) begin
                  state      <= gnt[DIR_IN] ? OPEN_IN : OPEN_OUT;
                  grant_in   <= gnt[DIR_IN];
                  grant_out  <= gnt[DIR_OUT];
                  last_grant <= gnt[DIR_IN] ? DIR_IN : DIR_OUT;
                  gate_open  <= 1'b1;
                  busy       <= 1'b1;
                  ref_cnt    <= count;
                  timer      <= '0;
               end
            end
            OPEN_IN, OPEN_OUT: begin
               // Completion takes priority over a coincident timeout.
               if (done || timer == TMO_LAST) begin
                  state       <= CLOSE;
                  gate_open   <= 1'b0;
                  grant_in    <= 1'b0;
                  grant_out   <= 1'b0;
                  timer       <= '0;
                  timeout_evt <= ~done;
               end else begin
                  timer   <= timer + 1'b1;
                  ref_cnt <= count;
               end
            end
            CLOSE: begin
               if (timer == GRD_LAST) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  timer <= '0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
         endcase
      end
   end

endmodule
